cbsc_sng_array: RTL and testbench
=================================

# cbsc_sng_array

Parametrised, multi-channel successor to the counter-based stochastic number generator (SNG) used by the deterministic SC MAC datapath. It converts CH unsigned WIDTH-bit operands into CH bit-streams of exactly 2^WIDTH bits each, all driven by one shared counter. Each stream carries exactly x ones. Two pattern modes are selectable per run: counter-based priority pattern or unary/thermometer. A start/valid/last handshake and a stall enable let the block feed downstream SC multipliers and accumulators with no gap between streams.

## Interface
- WIDTH, 7: operand width; stream length is 2^WIDTH.
- CH, 4: number of independent channels sharing the counter.
- clk in 1: rising-edge clock.
- rst in 1: reset, asynchronous, active-low.
- start in 1: request a new stream; sampled only when accepted (see Operation).
- mode in 1: 0 = counter-based pattern, 1 = unary; latched with x.
- x in CH*WIDTH: operands, channel i at x[i*WIDTH +: WIDTH]; latched on accept.
- en in 1: advance enable; low stalls the run.
- x_sn out CH: registered stream bits, one per channel.
- sn_valid out 1: x_sn holds a valid stream bit this cycle.
- sn_last out 1: marks the final (2^WIDTH-th) bit of a stream; asserted only with sn_valid.
- busy out 1: a run is in progress.

## Operation
- Latched state: x_q (CH*WIDTH), mode_q, and cnt (WIDTH bits).
- FSM states:
  - IDLE to RUN on accept.
  - RUN to IDLE after the last bit, unless a back-to-back accept occurs.
- Accept condition: start=1 while in IDLE, or start=1 in RUN on the edge that emits the last bit (cnt = 2^WIDTH-1 with en=1). start at any other time is ignored.
- On accept: x_q <= x, mode_q <= mode, cnt <= 0, state <= RUN.
- Each RUN edge with en=1:
  - x_sn[i] <= f(x_q[i], cnt).
  - sn_valid <= 1.
  - sn_last <= (cnt = 2^WIDTH-1).
  - cnt <= cnt+1, wrapping.
- Each RUN edge with en=0: sn_valid <= 0, sn_last <= 0; cnt, x_q, mode_q and x_sn hold.
- In IDLE: sn_valid <= 0, sn_last <= 0, x_sn <= 0.
- Mode 0, counter-based pattern:
  - k = number of trailing ones of cnt.
  - f = x_q[WIDTH-1-k] for k < WIDTH; f = 0 for cnt all-ones.
  - Bit j of x drives 2^j stream positions, so the stream has exactly x ones.
- Mode 1, unary: f = (x_q > cnt), unsigned. Ones fill the leading x positions.
- busy = (state = RUN).

## Timing
- Reset values: x_sn=0, sn_valid=0, sn_last=0, busy=0, cnt=0, x_q=0, mode_q=0, state=IDLE. Reset acts immediately and asynchronously.
- Accept at edge t:
  - busy=1 after t.
  - First bit (cnt=0) is valid after edge t+1, assuming en=1.
  - Last bit is valid after edge t+2^WIDTH, with sn_last=1.
- Latency start to first bit: 1 cycle. Stream duration: 2^WIDTH cycles plus the number of stalled cycles.
- Back-to-back accept on the last-bit edge: the next stream's first bit follows the last bit with no sn_valid gap. busy stays 1.
- Without re-accept: busy drops after the edge that emitted the last bit. sn_valid=0 the following cycle.
- x=0 yields all zeros in both modes. x=2^WIDTH-1 yields one zero: at cnt=all-ones in mode 0, and at the final position in mode 1.
- en low on the last-bit cycle: the last bit is deferred. No accept happens until en=1.
- Reset mid-run aborts the stream. No sn_last is produced.

## Structure
- Shared package cbsc_pkg holds:
  - mode encodings MODE_CB=1'b0 and MODE_UNARY=1'b1;
  - FSM state typedef {IDLE, RUN}.
- Sub-module sng_lane (one per channel, generate loop) contains:
  - inputs WIDTH-bit x_q, cnt, mode_q, and the advance strobe;
  - a trailing-ones priority mux and a comparator;
  - a registered x_sn bit.
- Top level owns the FSM, cnt, handshake flags and the x/mode latches.

## Test plan
All scenarios use WIDTH=7, CH=4.
1. Mode 0, x={64,1,0,127}, en=1:
   - ch0 alternates 1,0 starting with 1 (64 ones);
   - ch1 has its single one at bit index 63 (cnt=0111111);
   - ch2 is all zero;
   - ch3 has 127 ones with a zero at bit 127;
   - sn_last on the 128th sn_valid.
2. Mode 1, x={3,0,127,64}:
   - ch0 = 1,1,1 then zeros;
   - ch1 all zero;
   - ch2 has 127 ones then 0;
   - ch3 has 64 ones then 64 zeros.
3. en low for 5 cycles at cnt=40: sn_valid low for those 5 cycles, ones counts unchanged, sn_last 5 cycles later than unstalled.
4. start held high through the last bit with new x=5, mode 1: no sn_valid gap, busy stays 1, and the next stream carries exactly 5 ones at its start.
5. start pulsed at cnt=20: ignored, and stream content is unaffected.
6. rst low at cnt=50: all outputs 0 immediately. After release, start is accepted from IDLE and the first bit follows 1 cycle after accept.

Source files
------------

// File: rtl/cbsc_sng_array_pkg.sv
// rtl/cbsc_sng_array_pkg.sv - shared mode encodings and FSM state type for the SNG array
package cbsc_pkg;

  // Pattern selection, latched with the operands at accept time
  localparam logic MODE_CB    = 1'b0;
  localparam logic MODE_UNARY = 1'b1;

  // Run control: IDLE waits for start, RUN emits one stream bit per enabled edge
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/cbsc_sng_array_if.sv
// rtl/cbsc_sng_array_if.sv - handshake and stream bundle between the SNG array and its user
interface cbsc_sng_array_if #(
  parameter int WIDTH = 7,
  parameter int CH    = 4
);

  logic                  start;
  logic                  mode;
  logic [CH*WIDTH-1:0]   x;
  logic                  en;
  logic [CH-1:0]         x_sn;
  logic                  sn_valid;
  logic                  sn_last;
  logic                  busy;

  // The user side drives requests/operands and consumes the streams
  modport master (
    output start, mode, x, en,
    input  x_sn, sn_valid, sn_last, busy
  );

  // The generator side
  modport slave (
    input  start, mode, x, en,
    output x_sn, sn_valid, sn_last, busy
  );

endinterface

// File: rtl/cbsc_sng_array_lane.sv
// rtl/cbsc_sng_array_lane.sv - one channel: pattern function of (x_q, cnt) and its registered stream bit
module sng_lane
  import cbsc_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_q,
  input  logic [WIDTH-1:0] cnt,
  input  logic             mode_q,
  input  logic             advance,
  input  logic             clear,
  output logic             x_sn
);

  logic cb_bit;
  logic unary_bit;
  logic found;
  logic next_bit;

  // Trailing-ones priority mux: k trailing ones of cnt select x_q[WIDTH-1-k],
  // so bit j of x lands on exactly 2^j positions; all-ones cnt yields 0.
  always_comb begin
    cb_bit = 1'b0;
    found  = 1'b0;
    for (int j = 0; j < WIDTH; j++) begin
      if (!found && !cnt[j]) begin
        found  = 1'b1;
        cb_bit = x_q[WIDTH-1-j];
      end
    end
  end

  // Thermometer compare: the first x_q positions of the stream are ones
  always_comb begin
    unary_bit = (x_q > cnt);
    next_bit  = (mode_q == MODE_UNARY) ? unary_bit : cb_bit;
  end

  // Stream bit register: cleared in IDLE, held across stalls
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_sn <= 1'b0;
    end else if (clear) begin
      x_sn <= 1'b0;
    end else if (advance) begin
      x_sn <= next_bit;
    end
  end

endmodule

// File: rtl/cbsc_sng_array.sv
// rtl/cbsc_sng_array.sv - multi-channel counter-based stochastic number generator with shared counter
module cbsc_sng_array
  import cbsc_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int CH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  cbsc_sng_array_if.slave  bus
);

  state_t                state;
  state_t                state_nxt;
  logic [WIDTH-1:0]      cnt;
  logic [CH*WIDTH-1:0]   x_q;
  logic                  mode_q;
  logic                  sn_valid_q;
  logic                  sn_last_q;
  logic [CH-1:0]         x_sn;

  logic                  cnt_max;
  logic                  advance;
  logic                  last_edge;
  logic                  accept;
  logic                  in_idle;

  // Handshake decode: a new stream may start from IDLE or exactly on the
  // edge that emits the last bit of the current one, giving gapless chaining.
  always_comb begin
    in_idle   = (state == IDLE);
    cnt_max   = &cnt;
    advance   = (state == RUN) && bus.en;
    last_edge = advance && cnt_max;
    accept    = bus.start && (in_idle || last_edge);
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: a chained accept keeps RUN, otherwise the last bit ends the run
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN:  if (last_edge && !accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand/mode latches and the shared position counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q    <= '0;
      mode_q <= MODE_CB;
      cnt    <= '0;
    end else if (accept) begin
      x_q    <= bus.x;
      mode_q <= bus.mode;
      cnt    <= '0;
    end else if (advance) begin
      cnt    <= cnt + 1'b1;
    end
  end

  // Stream qualifiers: one valid per enabled RUN edge, last on the final position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sn_valid_q <= 1'b0;
      sn_last_q  <= 1'b0;
    end else begin
      sn_valid_q <= advance;
      sn_last_q  <= last_edge;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_lane
    sng_lane #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .x_q     (x_q[i*WIDTH +: WIDTH]),
      .cnt     (cnt),
      .mode_q  (mode_q),
      .advance (advance),
      .clear   (in_idle),
      .x_sn    (x_sn[i])
    );
  end

  assign bus.x_sn     = x_sn;
  assign bus.sn_valid = sn_valid_q;
  assign bus.sn_last  = sn_last_q;
  assign bus.busy     = (state == RUN);

endmodule

// File: tb/tb_cbsc_sng_array.sv
// tb/tb_cbsc_sng_array.sv - self-checking bench for cbsc_sng_array
module tb_cbsc_sng_array;

  localparam int W = 7;
  localparam int C = 4;
  localparam int N = 1 << W;
  localparam int NV = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cbsc_sng_array_if #(.WIDTH(W), .CH(C)) bus ();

  cbsc_sng_array #(.WIDTH(W), .CH(C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic               mode;
    logic [C*W-1:0]     xs;
    int                 stall_at;
    int                 stall_len;
    int                 pulse_at;
    logic [C-1:0][7:0]  exp_ones;
  } vec_t;

  vec_t vecs [NV];
  logic [N-1:0] got [C];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [C*W-1:0] pack4(input int a, input int b, input int c, input int d);
    return {d[6:0], c[6:0], b[6:0], a[6:0]};
  endfunction

  function automatic logic [C-1:0][7:0] ones4(input int a, input int b, input int c, input int d);
    logic [C-1:0][7:0] r;
    r[0] = a[7:0];
    r[1] = b[7:0];
    r[2] = c[7:0];
    r[3] = d[7:0];
    return r;
  endfunction

  // Reference: unary puts ones on positions below x; counter mode gives bit j
  // of x every position p with (p+1) mod 2^(W-j) == 2^(W-1-j), i.e. 2^j slots.
  function automatic logic model_bit(input logic m, input logic [W-1:0] xv, input int p);
    if (m) return (p < int'(xv));
    for (int j = 0; j < W; j++) begin
      if (((p + 1) % (1 << (W - j))) == (1 << (W - 1 - j))) return xv[j];
    end
    return 1'b0;
  endfunction

  task automatic start_idle(input logic m, input logic [C*W-1:0] xs);
    bus.x = xs;
    bus.mode = m;
    bus.start = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.x = ~xs;
    bus.mode = ~m;
  endtask

  // Called on the negedge right after the accepting edge.
  task automatic run_stream(input logic m, input logic [C*W-1:0] xs,
                            input logic [C-1:0][7:0] exp_ones,
                            input int stall_at, input int stall_len, input int pulse_at,
                            input bit chain, input logic nm, input logic [C*W-1:0] nxs);
    int nv, cyc, first_cyc, last_cyc, last_idx, nlast, stall_done, ones, mism;
    bit pulsed;
    nv = 0; cyc = 0; first_cyc = -1; last_cyc = -1; last_idx = -1;
    nlast = 0; stall_done = 0; pulsed = 1'b0;
    chk("busy_after_accept", bus.busy, 1);
    while (nv < N && cyc < 400) begin
      if (cyc > 0) begin
        @(negedge clk);
        if (bus.sn_valid) begin
          for (int i = 0; i < C; i++) got[i][nv] = bus.x_sn[i];
          if (first_cyc < 0) first_cyc = cyc;
          if (bus.sn_last) begin
            nlast++;
            last_idx = nv;
            last_cyc = cyc;
          end
          nv++;
        end else if (bus.sn_last) begin
          nlast++;
        end
      end
      if (nv < N) begin
        if (nv == stall_at && stall_done < stall_len) begin
          bus.en = 1'b0;
          stall_done++;
        end else begin
          bus.en = 1'b1;
        end
        if (chain && nv >= N - 8) begin
          bus.start = 1'b1;
          bus.mode = nm;
          bus.x = nxs;
        end else if (!pulsed && nv == pulse_at) begin
          bus.start = 1'b1;
          bus.mode = ~m;
          bus.x = ~xs;
          pulsed = 1'b1;
        end else begin
          bus.start = 1'b0;
        end
      end
      cyc++;
    end
    bus.start = 1'b0;
    bus.en = 1'b1;
    chk("bits_received", nv, N);
    chk("first_bit_cycle", first_cyc, (stall_at == 0) ? 1 + stall_len : 1);
    for (int i = 0; i < C; i++) begin
      ones = 0;
      mism = 0;
      for (int p = 0; p < N; p++) begin
        if (got[i][p]) ones++;
        if (got[i][p] !== model_bit(m, xs[i*W +: W], p)) mism++;
      end
      chk($sformatf("stream_mismatches_ch%0d", i), mism, 0);
      chk($sformatf("ones_ch%0d", i), ones, exp_ones[i]);
    end
    chk("sn_last_count", nlast, 1);
    chk("sn_last_index", last_idx, N - 1);
    chk("sn_last_cycle", last_cyc, N + stall_len);
    if (chain) begin
      chk("busy_kept_on_chain", bus.busy, 1);
    end else begin
      chk("busy_dropped", bus.busy, 0);
      @(negedge clk);
      chk("valid_after_end", bus.sn_valid, 0);
      chk("x_sn_idle", bus.x_sn, 0);
    end
  endtask

  initial begin
    int quiet;
    logic [C*W-1:0] rx;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.en = 1'b0;
    bus.x = '0;
    bus.mode = 1'b0;

    vecs[0] = '{1'b0, pack4(64, 1, 0, 127), -1, 0, -1, ones4(64, 1, 0, 127)};
    vecs[1] = '{1'b1, pack4(3, 0, 127, 64), -1, 0, -1, ones4(3, 0, 127, 64)};
    vecs[2] = '{1'b0, pack4(100, 37, 127, 0), 40, 5, -1, ones4(100, 37, 127, 0)};
    vecs[3] = '{1'b1, pack4(90, 1, 126, 55), -1, 0, 20, ones4(90, 1, 126, 55)};
    vecs[4] = '{1'b1, pack4(0, 127, 0, 127), 127, 3, -1, ones4(0, 127, 0, 127)};
    for (int v = 5; v < NV; v++) begin
      int a, b, c, d;
      a = $urandom_range(0, 127);
      b = $urandom_range(0, 127);
      c = $urandom_range(0, 127);
      d = $urandom_range(0, 127);
      vecs[v] = '{1'($urandom_range(0, 1)), pack4(a, b, c, d),
                  int'($urandom_range(0, 127)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 126)), ones4(a, b, c, d)};
    end

    repeat (2) @(negedge clk);
    chk("reset_x_sn", bus.x_sn, 0);
    chk("reset_valid", bus.sn_valid, 0);
    chk("reset_last", bus.sn_last, 0);
    chk("reset_busy", bus.busy, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < NV; v++) begin
      start_idle(vecs[v].mode, vecs[v].xs);
      run_stream(vecs[v].mode, vecs[v].xs, vecs[v].exp_ones, vecs[v].stall_at,
                 vecs[v].stall_len, vecs[v].pulse_at, 1'b0, 1'b0, '0);
      if (v == 0) begin
        chk("cb_ch0_pos0", got[0][0], 1);
        chk("cb_ch0_pos1", got[0][1], 0);
        chk("cb_ch1_pos63", got[1][63], 1);
        chk("cb_ch3_pos127", got[3][127], 0);
      end
      if (v == 1) begin
        chk("un_ch0_pos2", got[0][2], 1);
        chk("un_ch0_pos3", got[0][3], 0);
        chk("un_ch2_pos127", got[2][127], 0);
        chk("un_ch3_pos63", got[3][63], 1);
        chk("un_ch3_pos64", got[3][64], 0);
      end
    end

    // Back-to-back: start held high through the last bit with new operands
    rx = pack4($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    start_idle(1'b0, rx);
    run_stream(1'b0, rx, ones4(rx[6:0], rx[13:7], rx[20:14], rx[27:21]),
               -1, 0, -1, 1'b1, 1'b1, pack4(5, 5, 5, 5));
    run_stream(1'b1, pack4(5, 5, 5, 5), ones4(5, 5, 5, 5), -1, 0, -1, 1'b0, 1'b0, '0);

    // Reset in the middle of a stream
    start_idle(1'b1, pack4(127, 127, 127, 127));
    repeat (51) @(negedge clk);
    chk("pre_reset_x_sn", bus.x_sn, 4'hF);
    chk("pre_reset_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_reset_x_sn", bus.x_sn, 0);
    chk("async_reset_valid", bus.sn_valid, 0);
    chk("async_reset_last", bus.sn_last, 0);
    chk("async_reset_busy", bus.busy, 0);
    quiet = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bus.sn_valid || bus.sn_last) quiet++;
    end
    chk("no_output_in_reset", quiet, 0);
    rst = 1'b1;
    @(negedge clk);
    rx = pack4($urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127), $urandom_range(0, 127));
    start_idle(1'b0, rx);
    run_stream(1'b0, rx, ones4(rx[6:0], rx[13:7], rx[20:14], rx[27:21]),
               -1, 0, -1, 1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
